dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for an RV64 core.
// Accepts one load/store at a time, waits a fixed latency, then holds the
// response until the core consumes it. Word-organised 64-bit backing store.
module dmem_responder #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned LAT   = 2,
  parameter logic [63:0] BASE  = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [2:0]  req_func3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'd8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q;
  logic [2:0]  func3_q;
  logic [63:0] addr_q, wdata_q;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [63:0] mem [DEPTH];

  logic        accept, enter_resp;
  logic        s_wr;
  logic [2:0]  s_f3;
  logic [63:0] s_addr, s_wdata;
  logic [63:0] off, rd_word, shifted, wdata_sh, bit_mask, new_word;
  logic [IDX_W-1:0] idx;
  logic [2:0]  lane;
  logic [7:0]  size_mask, byte_en;
  logic        in_range, misal, illegal, fault, mem_we;
  logic        unused_ok;

  assign accept    = req_valid & req_ready;
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Next-state logic: count WAIT cycles so rsp_valid appears in the LAT-th cycle after the accept cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (LAT == 1) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(LAT - 1);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Access decode: with LAT==1 the response is formed in the accept cycle, so use the live request.
  always_comb begin
    s_wr    = (state_q == S_IDLE) ? req_wr    : wr_q;
    s_f3    = (state_q == S_IDLE) ? req_func3 : func3_q;
    s_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    s_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;

    off      = s_addr - BASE;
    in_range = (s_addr >= BASE) && (off < SPAN);
    idx      = off[IDX_W+2:3];
    lane     = s_addr[2:0];
    rd_word  = in_range ? mem[idx] : 64'd0;

    illegal = s_wr ? s_f3[2] : (s_f3 == 3'd7);
    case (s_f3[1:0])
      2'd1:    misal = lane[0];
      2'd2:    misal = (lane[1:0] != 2'd0);
      2'd3:    misal = (lane != 3'd0);
      default: misal = 1'b0;
    endcase
    fault = illegal | misal | ~in_range;

    shifted = rd_word >> {lane, 3'b000};

    case (s_f3[1:0])
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    byte_en = size_mask << lane;
    for (int i = 0; i < 8; i++) bit_mask[i*8 +: 8] = {8{byte_en[i]}};
    wdata_sh = s_wdata << {lane, 3'b000};
    new_word = (rd_word & ~bit_mask) | (wdata_sh & bit_mask);

    rdata_d = 64'd0;
    if (!fault && !s_wr) begin
      case (s_f3)
        3'd0:    rdata_d = {{56{shifted[7]}},  shifted[7:0]};
        3'd1:    rdata_d = {{48{shifted[15]}}, shifted[15:0]};
        3'd2:    rdata_d = {{32{shifted[31]}}, shifted[31:0]};
        3'd3:    rdata_d = shifted;
        3'd4:    rdata_d = {56'd0, shifted[7:0]};
        3'd5:    rdata_d = {48'd0, shifted[15:0]};
        3'd6:    rdata_d = {32'd0, shifted[31:0]};
        default: rdata_d = 64'd0;
      endcase
    end
    err_d  = fault;
    mem_we = enter_resp & s_wr & ~fault;
  end

  assign unused_ok = ^{off[63:IDX_W+3], off[2:0]};

  // Control state, captured request and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      func3_q <= 3'd0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= req_wr;
        func3_q <= req_func3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (enter_resp) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

  // Backing store write, committed on entry to RESP.
  // NOTE: the memory array has no reset so it maps onto RAM; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= new_word;
  end

endmodule
